// File: rtl/adc_frame_pack.sv
// Packs 12-bit offset-binary AD9226 samples into fixed-length byte packets on a valid/ready stream.
// Define ADC_PACK_HEADER_EN to prefix every packet with A5 5A seq[15:8] seq[7:0].
module adc_frame_pack #(
  parameter int PKT_SAMPLES = 256,
  parameter int FIFO_DEPTH  = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_en,
  input  logic        adc_data_en,
  input  logic [11:0] adc_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(2 * PKT_SAMPLES);

  localparam logic [AW:0]   FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   PTR_ONE       = (AW+1)'(1);
  localparam logic [CW-1:0] LAST_SAMPLE   = CW'(PKT_SAMPLES - 1);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [PW-1:0] PKT_ONE       = PW'(1);
  localparam logic [BW-1:0] LAST_BYTE     = BW'(2 * PKT_SAMPLES - 1);
  localparam logic [BW-1:0] BYTE_ONE      = BW'(1);

  typedef enum logic {
    WR_RUN,
    WR_PAD
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
`ifdef ADC_PACK_HEADER_EN
    RD_HDR,
`endif
    RD_PAY
  } rd_state_t;

  // Sample-word FIFO, one extra pointer bit to tell full from empty.
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_full;
  logic [15:0]   rd_word;

  wr_state_t     wr_state, wr_state_d;
  logic          sample_en_q;
  logic [CW-1:0] wr_cnt;
  logic [PW-1:0] pkt_cnt;
  logic          wr_en;
  logic [15:0]   wr_word;
  logic          pkt_done, pkt_inc, pkt_dec;
  logic          ovf_set;

  rd_state_t     rd_state, rd_state_d;
  logic [BW-1:0] byte_cnt, byte_cnt_d;
  logic          rd_en;

`ifdef ADC_PACK_HEADER_EN
  logic [1:0]    hdr_cnt, hdr_cnt_d;
  logic [15:0]   seq, seq_d;
  logic [7:0]    hdr_byte;
`endif

  assign fifo_full = (wr_ptr - rd_ptr) == FIFO_FULL_CNT;
  assign rd_word   = mem[rd_ptr[AW-1:0]];
  assign pkt_done  = (wr_cnt == LAST_SAMPLE);
  assign pkt_inc   = wr_en && pkt_done;
  assign busy      = (rd_state != RD_IDLE) || (pkt_cnt != '0);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    wr_state_d = wr_state;
    wr_en      = 1'b0;
    wr_word    = '0;
    ovf_set    = 1'b0;
    case (wr_state)
      WR_RUN: begin
        if (sample_en && adc_data_en) begin
          if (fifo_full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_word = {4'b0000, adc_data};
          end
        end else if (sample_en_q && !sample_en && wr_cnt != '0) begin
          wr_state_d = WR_PAD;
        end
      end
      WR_PAD: begin
        // Padding owns the write port until the packet is complete.
        if (sample_en && adc_data_en) ovf_set = 1'b1;
        if (!fifo_full) begin
          wr_en = 1'b1;
          if (pkt_done) wr_state_d = WR_RUN;
        end
      end
      default: wr_state_d = WR_RUN;
    endcase
  end

`ifdef ADC_PACK_HEADER_EN
  always_comb begin
    case (hdr_cnt)
      2'd0:    hdr_byte = 8'hA5;
      2'd1:    hdr_byte = 8'h5A;
      2'd2:    hdr_byte = seq[15:8];
      default: hdr_byte = seq[7:0];
    endcase
  end
`endif

  // Outputs decode straight from state so they cannot change while a byte is stalled.
  always_comb begin
    rd_state_d = rd_state;
    byte_cnt_d = byte_cnt;
    rd_en      = 1'b0;
    pkt_dec    = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
`ifdef ADC_PACK_HEADER_EN
    hdr_cnt_d  = hdr_cnt;
    seq_d      = seq;
`endif
    case (rd_state)
      RD_IDLE: begin
        if (pkt_cnt != '0) begin
          byte_cnt_d = '0;
`ifdef ADC_PACK_HEADER_EN
          hdr_cnt_d  = 2'd0;
          rd_state_d = RD_HDR;
`else
          rd_state_d = RD_PAY;
`endif
        end
      end
`ifdef ADC_PACK_HEADER_EN
      RD_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        if (tx_ready) begin
          hdr_cnt_d = hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd3) rd_state_d = RD_PAY;
        end
      end
`endif
      RD_PAY: begin
        tx_valid = 1'b1;
        tx_data  = byte_cnt[0] ? rd_word[7:0] : rd_word[15:8];
        tx_last  = (byte_cnt == LAST_BYTE);
        if (tx_ready) begin
          rd_en = byte_cnt[0];
          if (byte_cnt == LAST_BYTE) begin
            rd_state_d = RD_IDLE;
            pkt_dec    = 1'b1;
`ifdef ADC_PACK_HEADER_EN
            seq_d      = seq + 16'd1;
`endif
          end else begin
            byte_cnt_d = byte_cnt + BYTE_ONE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state    <= WR_RUN;
      sample_en_q <= 1'b0;
      wr_cnt      <= '0;
      pkt_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf         <= 1'b0;
      rd_state    <= RD_IDLE;
      byte_cnt    <= '0;
`ifdef ADC_PACK_HEADER_EN
      hdr_cnt     <= 2'd0;
      seq         <= 16'd0;
`endif
    end else begin
      wr_state    <= wr_state_d;
      sample_en_q <= sample_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        wr_cnt <= pkt_done ? '0 : wr_cnt + CNT_ONE;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + PKT_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PKT_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      rd_state    <= rd_state_d;
      byte_cnt    <= byte_cnt_d;
`ifdef ADC_PACK_HEADER_EN
      hdr_cnt     <= hdr_cnt_d;
      seq         <= seq_d;
`endif
    end
  end

  // NOTE: storage is not reset; clearing the pointers is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

endmodule

// File: tb/tb_adc_frame_pack.sv
// Scoreboard bench for adc_frame_pack: stimulus pushes expected bytes, per-DUT monitors pop and compare.
module tb_adc_frame_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        a_sample_en, a_adc_data_en, a_tx_ready, a_ovf_clr;
  logic [11:0] a_adc_data;
  logic [7:0]  a_tx_data;
  logic        a_tx_valid, a_tx_last, a_busy, a_ovf;

  logic        b_sample_en, b_adc_data_en, b_tx_ready, b_ovf_clr;
  logic [11:0] b_adc_data;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid, b_tx_last, b_busy, b_ovf;

  adc_frame_pack #(.PKT_SAMPLES(4), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .sample_en(a_sample_en), .adc_data_en(a_adc_data_en),
    .adc_data(a_adc_data), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_last(a_tx_last), .busy(a_busy), .ovf(a_ovf), .ovf_clr(a_ovf_clr)
  );

  adc_frame_pack #(.PKT_SAMPLES(1), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .sample_en(b_sample_en), .adc_data_en(b_adc_data_en),
    .adc_data(b_adc_data), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_last(b_tx_last), .busy(b_busy), .ovf(b_ovf), .ovf_clr(b_ovf_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  exp_a[$];
  logic [8:0]  exp_b[$];
  logic [15:0] seq_a, seq_b;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input bit to_b, input logic [7:0] d, input bit last);
    if (to_b) exp_b.push_back({last, d});
    else      exp_a.push_back({last, d});
  endtask

  task automatic push_hdr(input bit to_b);
`ifdef ADC_PACK_HEADER_EN
    logic [15:0] s;
    s = to_b ? seq_b : seq_a;
    push_byte(to_b, 8'hA5, 1'b0);
    push_byte(to_b, 8'h5A, 1'b0);
    push_byte(to_b, s[15:8], 1'b0);
    push_byte(to_b, s[7:0], 1'b0);
`endif
    if (to_b) seq_b++;
    else      seq_a++;
  endtask

  task automatic push_word(input bit to_b, input logic [11:0] w, input bit last);
    push_byte(to_b, {4'h0, w[11:8]}, 1'b0);
    push_byte(to_b, w[7:0], last);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_a(input logic [11:0] d);
    a_adc_data    = d;
    a_adc_data_en = 1'b1;
    cycles(1);
    a_adc_data_en = 1'b0;
  endtask

  task automatic strobe_b(input logic [11:0] d);
    b_adc_data    = d;
    b_adc_data_en = 1'b1;
    cycles(1);
    b_adc_data_en = 1'b0;
  endtask

  task automatic wait_drain(input bit to_b, input bit toggle, input string name);
    int k;
    k = 0;
    while ((to_b ? exp_b.size() : exp_a.size()) != 0 && k < 400) begin
      if (toggle) a_tx_ready = ~a_tx_ready;
      cycles(1);
      k++;
    end
    a_tx_ready = 1'b1;
    check(name, 16'((to_b ? exp_b.size() : exp_a.size()) == 0), 16'd1);
  endtask

  // Monitor for dut_a: stalled bytes must hold, accepted bytes must match the scoreboard.
  logic [8:0] a_hold, a_got;
  bit         a_stalled = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      a_stalled = 1'b0;
    end else begin
      if (a_stalled && a_tx_valid)
        check("a_hold_stable", {7'b0, a_tx_last, a_tx_data}, {7'b0, a_hold});
      if (a_tx_valid && a_tx_ready) begin
        if (exp_a.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_unexpected: got byte 0x%0h last %0b, none expected", a_tx_data, a_tx_last);
        end else begin
          a_got = exp_a.pop_front();
          check("a_byte", {7'b0, a_tx_last, a_tx_data}, {7'b0, a_got});
        end
        a_stalled = 1'b0;
      end else if (a_tx_valid) begin
        a_stalled = 1'b1;
        a_hold    = {a_tx_last, a_tx_data};
      end else begin
        a_stalled = 1'b0;
      end
    end
  end

  logic [8:0] b_got;
  always @(negedge clk) begin
    if (reset_n && b_tx_valid && b_tx_ready) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected: got byte 0x%0h last %0b, none expected", b_tx_data, b_tx_last);
      end else begin
        b_got = exp_b.pop_front();
        check("b_byte", {7'b0, b_tx_last, b_tx_data}, {7'b0, b_got});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n       = 1'b0;
    a_sample_en   = 1'b0; a_adc_data_en = 1'b0; a_adc_data = '0; a_tx_ready = 1'b1; a_ovf_clr = 1'b0;
    b_sample_en   = 1'b0; b_adc_data_en = 1'b0; b_adc_data = '0; b_tx_ready = 1'b1; b_ovf_clr = 1'b0;
    seq_a = '0;
    seq_b = '0;
    cycles(3);

    check("rst_tx_valid", 16'(a_tx_valid), 16'd0);
    check("rst_tx_last",  16'(a_tx_last),  16'd0);
    check("rst_tx_data",  16'(a_tx_data),  16'h00);
    check("rst_busy",     16'(a_busy),     16'd0);
    check("rst_ovf",      16'(a_ovf),      16'd0);
    check("rst_b_valid",  16'(b_tx_valid), 16'd0);
    reset_n = 1'b1;
    cycles(2);

    // First packet, consumer always ready; tx_valid must follow within two clocks.
    a_sample_en = 1'b1;
    push_hdr(1'b0);
    push_word(1'b0, 12'h123, 1'b0);
    push_word(1'b0, 12'h456, 1'b0);
    push_word(1'b0, 12'h789, 1'b0);
    push_word(1'b0, 12'hABC, 1'b1);
    strobe_a(12'h123);
    strobe_a(12'h456);
    strobe_a(12'h789);
    strobe_a(12'hABC);
    a_sample_en = 1'b0;
    k = 0;
    while (!a_tx_valid && k < 2) begin
      cycles(1);
      k++;
    end
    check("pkt0_latency", 16'(a_tx_valid), 16'd1);
    wait_drain(1'b0, 1'b0, "pkt0_drained");
    check("pkt0_busy_after", 16'(a_busy), 16'd0);

    // Second packet with the consumer toggling ready every cycle.
    a_tx_ready  = 1'b0;
    a_sample_en = 1'b1;
    push_hdr(1'b0);
    push_word(1'b0, 12'h123, 1'b0);
    push_word(1'b0, 12'h456, 1'b0);
    push_word(1'b0, 12'h789, 1'b0);
    push_word(1'b0, 12'hABC, 1'b1);
    strobe_a(12'h123);
    strobe_a(12'h456);
    strobe_a(12'h789);
    strobe_a(12'hABC);
    a_sample_en = 1'b0;
    wait_drain(1'b0, 1'b1, "pkt1_toggle_drained");

    // Window closes after two samples: the packet is padded with zero words.
    a_sample_en = 1'b1;
    push_hdr(1'b0);
    push_word(1'b0, 12'h111, 1'b0);
    push_word(1'b0, 12'h222, 1'b0);
    push_word(1'b0, 12'h000, 1'b0);
    push_word(1'b0, 12'h000, 1'b1);
    strobe_a(12'h111);
    strobe_a(12'h222);
    a_sample_en = 1'b0;
    wait_drain(1'b0, 1'b0, "pad_drained");
    check("pad_no_ovf", 16'(a_ovf), 16'd0);
    check("pad_busy_after", 16'(a_busy), 16'd0);

    // Fill the 8-word FIFO with the consumer stalled, then overflow it.
    a_tx_ready  = 1'b0;
    a_sample_en = 1'b1;
    for (int i = 1; i <= 8; i++) strobe_a(12'(i));
    check("full_no_ovf_yet", 16'(a_ovf), 16'd0);
    strobe_a(12'h009);
    check("ovf_set", 16'(a_ovf), 16'd1);
    check("ovf_busy", 16'(a_busy), 16'd1);
    a_ovf_clr = 1'b1;
    strobe_a(12'h00A);
    a_ovf_clr = 1'b0;
    check("ovf_set_wins_clr", 16'(a_ovf), 16'd1);
    a_ovf_clr = 1'b1;
    cycles(1);
    a_ovf_clr = 1'b0;
    check("ovf_cleared", 16'(a_ovf), 16'd0);
    a_sample_en = 1'b0;
    push_hdr(1'b0);
    for (int i = 1; i <= 4; i++) push_word(1'b0, 12'(i), i == 4);
    push_hdr(1'b0);
    for (int i = 5; i <= 8; i++) push_word(1'b0, 12'(i), i == 8);
    a_tx_ready = 1'b1;
    wait_drain(1'b0, 1'b0, "ovf_two_pkts_drained");
    check("ovf_busy_after", 16'(a_busy), 16'd0);

    // Reset in the middle of a payload discards everything.
    a_sample_en = 1'b1;
    push_hdr(1'b0);
    push_word(1'b0, 12'h321, 1'b0);
    push_word(1'b0, 12'h654, 1'b0);
    push_word(1'b0, 12'h987, 1'b0);
    push_word(1'b0, 12'hCBA, 1'b1);
    strobe_a(12'h321);
    strobe_a(12'h654);
    strobe_a(12'h987);
    strobe_a(12'hCBA);
    a_sample_en = 1'b0;
    k = 0;
    while (exp_a.size() > 3 && k < 100) begin
      cycles(1);
      k++;
    end
    check("mid_payload_reached", 16'(exp_a.size() <= 3), 16'd1);
    reset_n = 1'b0;
    cycles(1);
    check("rst_mid_tx_valid", 16'(a_tx_valid), 16'd0);
    check("rst_mid_busy", 16'(a_busy), 16'd0);
    exp_a.delete();
    seq_a = '0;
    seq_b = '0;
    reset_n = 1'b1;
    cycles(20);
    check("rst_no_resume_busy", 16'(a_busy), 16'd0);
    check("rst_no_resume_valid", 16'(a_tx_valid), 16'd0);

    a_sample_en = 1'b1;
    push_hdr(1'b0);
    push_word(1'b0, 12'h0F0, 1'b0);
    push_word(1'b0, 12'h00F, 1'b0);
    push_word(1'b0, 12'h800, 1'b0);
    push_word(1'b0, 12'h7FF, 1'b1);
    strobe_a(12'h0F0);
    strobe_a(12'h00F);
    strobe_a(12'h800);
    strobe_a(12'h7FF);
    a_sample_en = 1'b0;
    wait_drain(1'b0, 1'b0, "post_rst_drained");

    // Single-sample packets.
    b_sample_en = 1'b1;
    push_hdr(1'b1);
    push_word(1'b1, 12'hFFF, 1'b1);
    push_hdr(1'b1);
    push_word(1'b1, 12'h000, 1'b1);
    strobe_b(12'hFFF);
    strobe_b(12'h000);
    b_sample_en = 1'b0;
    wait_drain(1'b1, 1'b0, "b_pkts_drained");
    check("b_busy_after", 16'(b_busy), 16'd0);
    check("b_ovf", 16'(b_ovf), 16'd0);

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
